apple1_keyboard: RTL and testbench



---
 rtl/apple1_pkg.sv | 38 +++
 rtl/ps2_scancode_rom.sv | 75 +++++++
 rtl/apple1_keyboard.sv | 214 +++++++++++++++++++++
 tb/tb_apple1_keyboard.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apple1_pkg.sv
// ============================================================================
//  Module      : apple1_pkg
//  Description : Shared types and constants for the Apple-1 PS/2 keyboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apple1_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;
   localparam logic [7:0] SC_ESC    = 8'h76;
   localparam logic [7:0] SC_F11    = 8'h78;
   localparam logic [7:0] SC_F12    = 8'h07;

   localparam logic [6:0] ASCII_CR     = 7'h0D;
   localparam logic [6:0] ASCII_ESC    = 7'h1B;
   localparam logic [6:0] ASCII_RUBOUT = 7'h5F;

   function automatic logic is_letter(input logic [6:0] c);
      return (c >= 7'h41) && (c <= 7'h5A);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_scancode_rom.sv
// ============================================================================
//  Module      : ps2_scancode_rom
//  Description : Set-2 scancode to Apple-1 ASCII lookup (uppercase only).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scancode_rom
   import apple1_pkg::*;
(
   input  logic       i_shift,
   input  logic [7:0] i_scancode,
   output logic       o_valid,
   output logic [6:0] o_ascii
);

   always_comb begin
      o_valid = 1'b1;
      o_ascii = 7'h00;
      case (i_scancode)
         8'h1C: o_ascii = 7'h41;
         8'h32: o_ascii = 7'h42;
         8'h21: o_ascii = 7'h43;
         8'h23: o_ascii = 7'h44;
         8'h24: o_ascii = 7'h45;
         8'h2B: o_ascii = 7'h46;
         8'h34: o_ascii = 7'h47;
         8'h33: o_ascii = 7'h48;
         8'h43: o_ascii = 7'h49;
         8'h3B: o_ascii = 7'h4A;
         8'h42: o_ascii = 7'h4B;
         8'h4B: o_ascii = 7'h4C;
         8'h3A: o_ascii = 7'h4D;
         8'h31: o_ascii = 7'h4E;
         8'h44: o_ascii = 7'h4F;
         8'h4D: o_ascii = 7'h50;
         8'h15: o_ascii = 7'h51;
         8'h2D: o_ascii = 7'h52;
         8'h1B: o_ascii = 7'h53;
         8'h2C: o_ascii = 7'h54;
         8'h3C: o_ascii = 7'h55;
         8'h2A: o_ascii = 7'h56;
         8'h1D: o_ascii = 7'h57;
         8'h22: o_ascii = 7'h58;
         8'h35: o_ascii = 7'h59;
         8'h1A: o_ascii = 7'h5A;
         // Digit row: shifted symbols follow the US layout
         8'h45: o_ascii = i_shift ? 7'h29 : 7'h30;
         8'h16: o_ascii = i_shift ? 7'h21 : 7'h31;
         8'h1E: o_ascii = i_shift ? 7'h40 : 7'h32;
         8'h26: o_ascii = i_shift ? 7'h23 : 7'h33;
         8'h25: o_ascii = i_shift ? 7'h24 : 7'h34;
         8'h2E: o_ascii = i_shift ? 7'h25 : 7'h35;
         8'h36: o_ascii = i_shift ? 7'h5E : 7'h36;
         8'h3D: o_ascii = i_shift ? 7'h26 : 7'h37;
         8'h3E: o_ascii = i_shift ? 7'h2A : 7'h38;
         8'h46: o_ascii = i_shift ? 7'h28 : 7'h39;
         8'h29: o_ascii = 7'h20;
         8'h4E: o_ascii = i_shift ? 7'h5F : 7'h2D;
         8'h55: o_ascii = i_shift ? 7'h2B : 7'h3D;
         8'h4C: o_ascii = i_shift ? 7'h3A : 7'h3B;
         8'h52: o_ascii = i_shift ? 7'h22 : 7'h27;
         8'h41: o_ascii = i_shift ? 7'h3C : 7'h2C;
         8'h49: o_ascii = i_shift ? 7'h3E : 7'h2E;
         8'h4A: o_ascii = i_shift ? 7'h3F : 7'h2F;
         SC_ENTER: o_ascii = ASCII_CR;
         SC_BKSP:  o_ascii = ASCII_RUBOUT;
         SC_ESC:   o_ascii = ASCII_ESC;
         default:  o_valid = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/apple1_keyboard.sv
// ============================================================================
//  Module      : apple1_keyboard
//  Description : PS/2 receiver and decoder presenting the Apple-1 KBD/KBDCR pair.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apple1_keyboard
   import apple1_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int SYNC_STAGES    = 2
)
(
   input  logic       sys_clock,
   input  logic       reset,
   input  logic       cpu_clken,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       address,
   input  logic       r_en,
   output logic [7:0] dout,
   output logic       key_ready,
   output logic       clr_screen,
   output logic       reset_req
);

   localparam int                    c_TIMER_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TIMER_W-1:0]  c_TIMEOUT_END = c_TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_prev;
   logic                   w_fall;
   logic                   w_data;

   rx_state_t              r_state;
   logic [2:0]             r_bit_cnt;
   logic [7:0]             r_shreg;
   logic                   r_par;
   logic                   r_par_ok;
   logic [c_TIMER_W-1:0]   r_timer;
   logic                   r_byte_valid;
   logic [7:0]             r_byte;

   logic                   r_shift_key;
   logic                   r_ctrl;
   logic                   r_brk;
   logic                   r_ext;
   logic                   r_load_pend;
   logic [6:0]             r_load_char;
   logic                   r_clr_pend;
   logic                   r_rst_pend;
   logic [6:0]             r_char;
   logic                   r_overrun;

   logic                   w_rom_valid;
   logic [6:0]             w_rom_ascii;
   logic [6:0]             w_char;
   logic                   w_rd_kbd;
   logic                   w_rd_cr;

   // Lines idle high, so presetting the synchronizers to 1 avoids a false edge
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
         r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
      end
   end

   assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
   assign w_data = r_dat_sync[SYNC_STAGES-1];

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         r_state      <= IDLE;
         r_bit_cnt    <= 3'd0;
         r_shreg      <= 8'h00;
         r_par        <= 1'b0;
         r_par_ok     <= 1'b0;
         r_timer      <= '0;
         r_byte_valid <= 1'b0;
         r_byte       <= 8'h00;
      end else begin
         r_byte_valid <= 1'b0;
         if (w_fall || (r_state == IDLE)) r_timer <= '0;
         else                             r_timer <= r_timer + 1'b1;

         if (w_fall) begin
            unique case (r_state)
               IDLE: begin
                  if (!w_data) begin
                     r_state   <= DATA;
                     r_bit_cnt <= 3'd0;
                     r_par     <= 1'b0;
                  end
               end
               DATA: begin
                  r_shreg   <= {w_data, r_shreg[7:1]};
                  r_par     <= r_par ^ w_data;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_state <= PARITY;
               end
               PARITY: begin
                  r_par_ok <= r_par ^ w_data;
                  r_state  <= STOP;
               end
               STOP: begin
                  if (w_data && r_par_ok) begin
                     r_byte_valid <= 1'b1;
                     r_byte       <= r_shreg;
                  end
                  r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end else if ((r_state != IDLE) && (r_timer == c_TIMEOUT_END)) begin
            r_state <= IDLE;
         end
      end
   end

   ps2_scancode_rom u_rom (
      .i_shift    (r_shift_key),
      .i_scancode (r_byte),
      .o_valid    (w_rom_valid),
      .o_ascii    (w_rom_ascii)
   );

   assign w_char = (r_ctrl && is_letter(w_rom_ascii)) ? (w_rom_ascii & 7'h1F) : w_rom_ascii;

   // Decode stage: prefix flags persist until a non-prefix byte closes the sequence
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         r_shift_key <= 1'b0;
         r_ctrl      <= 1'b0;
         r_brk       <= 1'b0;
         r_ext       <= 1'b0;
         r_load_pend <= 1'b0;
         r_load_char <= 7'h00;
         r_clr_pend  <= 1'b0;
         r_rst_pend  <= 1'b0;
      end else begin
         r_load_pend <= 1'b0;
         r_clr_pend  <= 1'b0;
         r_rst_pend  <= 1'b0;
         if (r_byte_valid) begin
            if (r_byte == SC_EXT) begin
               r_ext <= 1'b1;
            end else if (r_byte == SC_BREAK) begin
               r_brk <= 1'b1;
            end else begin
               r_ext <= 1'b0;
               r_brk <= 1'b0;
               if ((r_byte == SC_LSHIFT) || (r_byte == SC_RSHIFT)) begin
                  r_shift_key <= ~r_brk;
               end else if (r_byte == SC_CTRL) begin
                  r_ctrl <= ~r_brk;
               end else if (!r_brk) begin
                  if (r_ext) begin
                     if (r_byte == SC_ENTER) begin
                        r_load_pend <= 1'b1;
                        r_load_char <= ASCII_CR;
                     end
                  end else if (r_byte == SC_F11) begin
                     r_clr_pend <= 1'b1;
                  end else if (r_byte == SC_F12) begin
                     r_rst_pend <= 1'b1;
                  end else if (w_rom_valid) begin
                     r_load_pend <= 1'b1;
                     r_load_char <= w_char;
                  end
               end
            end
         end
      end
   end

   assign w_rd_kbd = cpu_clken & r_en & ~address;
   assign w_rd_cr  = cpu_clken & r_en &  address;

   // A load coinciding with a KBD read wins on key_ready and never flags overrun
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         r_char     <= 7'h00;
         key_ready  <= 1'b0;
         r_overrun  <= 1'b0;
         dout       <= 8'h00;
         clr_screen <= 1'b0;
         reset_req  <= 1'b0;
      end else begin
         clr_screen <= r_clr_pend;
         reset_req  <= r_rst_pend;
         if (w_rd_kbd)     dout <= {1'b1, r_char};
         else if (w_rd_cr) dout <= {key_ready, r_overrun, 6'b000000};

         if (r_load_pend) begin
            r_char    <= r_load_char;
            key_ready <= 1'b1;
         end else if (w_rd_kbd) begin
            key_ready <= 1'b0;
         end
         r_overrun <= w_rd_kbd ? 1'b0 : (r_overrun | (r_load_pend & key_ready));
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_apple1_keyboard.sv
// ============================================================================
//  Module      : tb_apple1_keyboard
//  Description : Self-checking bench for apple1_keyboard with a keyboard model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apple1_keyboard;

   localparam int TB_TIMEOUT = 300;
   localparam int TB_SYNC    = 2;
   localparam int HALF       = 8;
   // raw stop-bit fall -> synchronizer, edge detect, receiver, then 2-cycle decode
   localparam int LOAD_LAT   = TB_SYNC + 3;

   logic       sys_clock = 1'b0;
   logic       reset     = 1'b1;
   logic       cpu_clken = 1'b0;
   logic       ps2_clk   = 1'b1;
   logic       ps2_data  = 1'b1;
   logic       address   = 1'b0;
   logic       r_en      = 1'b0;
   logic [7:0] dout;
   logic       key_ready;
   logic       clr_screen;
   logic       reset_req;

   apple1_keyboard #(.TIMEOUT_CYCLES(TB_TIMEOUT), .SYNC_STAGES(TB_SYNC)) dut (
      .sys_clock  (sys_clock),
      .reset      (reset),
      .cpu_clken  (cpu_clken),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .address    (address),
      .r_en       (r_en),
      .dout       (dout),
      .key_ready  (key_ready),
      .clr_screen (clr_screen),
      .reset_req  (reset_req)
   );

   always #5 sys_clock = ~sys_clock;

   int cyc = 0;
   always @(posedge sys_clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- keyboard model ----------------
   typedef struct { int due; logic [7:0] b; } ev_t;
   ev_t byte_q[$];
   ev_t read_q[$];

   logic [7:0] LET_SC [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                               8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                               8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
   logic [7:0] DIG_SC [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
   logic [7:0] PUN_SC [8]  = '{8'h29,8'h4E,8'h55,8'h4C,8'h52,8'h41,8'h49,8'h4A};
   string DIG_UN = "0123456789";
   string DIG_SH = ")!@#$%^&*(";
   string PUN_UN = " -=;',./";
   string PUN_SH = " _+:\"<>?";

   bit       m_ready, m_ovr, m_shift, m_ctrl, m_brk, m_ext;
   logic [6:0] m_char;
   logic [7:0] m_dout;
   int       m_clr = 0, m_rst = 0, obs_clr = 0, obs_rst = 0;
   bit       run = 0;
   logic     prev_clr = 0, prev_rst = 0;

   task automatic model_clear();
      m_ready = 0; m_ovr = 0; m_shift = 0; m_ctrl = 0; m_brk = 0; m_ext = 0;
      m_char = 0; m_dout = 0;
      byte_q.delete(); read_q.delete();
   endtask

   task automatic model_load(input logic [6:0] c);
      if (m_ready) m_ovr = 1;
      m_ready = 1;
      m_char  = c;
   endtask

   task automatic model_key(input logic [7:0] b);
      logic [7:0] t;
      if (b == 8'h5A)      model_load(7'h0D);
      else if (b == 8'h66) model_load(7'h5F);
      else if (b == 8'h76) model_load(7'h1B);
      for (int i = 0; i < 26; i++)
         if (LET_SC[i] == b) begin
            t = 8'h41 + 8'(i);
            model_load(m_ctrl ? (t[6:0] & 7'h1F) : t[6:0]);
         end
      for (int i = 0; i < 10; i++)
         if (DIG_SC[i] == b) begin
            t = m_shift ? DIG_SH[i] : DIG_UN[i];
            model_load(t[6:0]);
         end
      for (int i = 0; i < 8; i++)
         if (PUN_SC[i] == b) begin
            t = m_shift ? PUN_SH[i] : PUN_UN[i];
            model_load(t[6:0]);
         end
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0)      m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
         else if (b == 8'h14)          m_ctrl  = !m_brk;
         else if (!m_brk) begin
            if (m_ext) begin
               if (b == 8'h5A) model_load(7'h0D);
            end
            else if (b == 8'h78) m_clr++;
            else if (b == 8'h07) m_rst++;
            else model_key(b);
         end
         m_ext = 0; m_brk = 0;
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge sys_clock) begin
      if (run && !reset) begin
         while (read_q.size() > 0 && read_q[0].due == cyc) begin
            if (read_q[0].b == 8'd0) begin
               m_dout = {1'b1, m_char}; m_ready = 0; m_ovr = 0;
            end else begin
               m_dout = {m_ready, m_ovr, 6'b0};
            end
            void'(read_q.pop_front());
         end
         while (byte_q.size() > 0 && byte_q[0].due == cyc) begin
            model_byte(byte_q[0].b);
            void'(byte_q.pop_front());
         end
         check("key_ready", {31'd0, key_ready}, {31'd0, m_ready});
         check("dout", {24'd0, dout}, {24'd0, m_dout});
         if (clr_screen) begin obs_clr++; check("clr_width", {31'd0, prev_clr}, 0); end
         if (reset_req)  begin obs_rst++; check("rst_width", {31'd0, prev_rst}, 0); end
      end
      prev_clr = clr_screen;
      prev_rst = reset_req;
   end

   // ---------------- stimulus ----------------
   task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                             input int nbits = 11, input int read_off = -1);
      logic [10:0] bits;
      ev_t e;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge sys_clock); ps2_data = bits[i];
         repeat (HALF - 1) @(negedge sys_clock);
         ps2_clk = 1'b0;
         if (i == 10 && (^bits[9:1]) && bits[10]) begin
            e.due = cyc + LOAD_LAT; e.b = b; byte_q.push_back(e);
         end
         for (int j = 1; j <= HALF; j++) begin
            @(negedge sys_clock);
            if (i == 10 && j == read_off) begin
               address = 0; r_en = 1; cpu_clken = 1;
               e.due = cyc + 1; e.b = 8'd0; read_q.push_back(e);
            end
            if (i == 10 && j == read_off + 1) begin r_en = 0; cpu_clken = 0; end
         end
         ps2_clk = 1'b1;
      end
      @(negedge sys_clock); ps2_data = 1'b1;
      repeat (4) @(negedge sys_clock);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 0, 0, 11, -1);
   endtask

   task automatic do_read(input bit adr, input bit en);
      ev_t e;
      @(negedge sys_clock);
      address = adr; r_en = 1; cpu_clken = en;
      if (en) begin e.due = cyc + 1; e.b = {7'd0, adr}; read_q.push_back(e); end
      @(negedge sys_clock);
      r_en = 0; cpu_clken = 0;
   endtask

   task automatic read_expect(input string nm, input bit adr, input logic [7:0] exp);
      do_read(adr, 1);
      check(nm, {24'd0, dout}, {24'd0, exp});
   endtask

   task automatic reset_dut();
      @(negedge sys_clock); reset = 1;
      repeat (3) @(negedge sys_clock);
      model_clear();
      reset = 0;
   endtask

   logic [7:0] pool[$];

   initial begin
      int k;
      logic [7:0] key;
      foreach (LET_SC[i]) pool.push_back(LET_SC[i]);
      foreach (DIG_SC[i]) pool.push_back(DIG_SC[i]);
      foreach (PUN_SC[i]) pool.push_back(PUN_SC[i]);
      pool.push_back(8'h5A); pool.push_back(8'h66); pool.push_back(8'h76);
      model_clear();
      repeat (4) @(negedge sys_clock);
      reset = 0; run = 1;
      @(negedge sys_clock);
      check("rst_dout", {24'd0, dout}, 0);
      check("rst_ready", {31'd0, key_ready}, 0);
      check("rst_clr", {31'd0, clr_screen}, 0);
      check("rst_req", {31'd0, reset_req}, 0);
      read_expect("rst_kbdcr", 1, 8'h00);

      send(8'h1C);
      check("A_ready", {31'd0, key_ready}, 1);
      read_expect("A_kbd", 0, 8'hC1);
      check("A_cleared", {31'd0, key_ready}, 0);

      send(8'h12); send(8'h16);
      read_expect("bang", 0, 8'hA1);
      send(8'hF0); send(8'h12); send(8'h16);
      read_expect("one", 0, 8'hB1);

      send_frame(8'h1C, 1, 0, 11, -1);
      check("badpar_ready", {31'd0, key_ready}, 0);
      send_frame(8'h1C, 0, 1, 11, -1);
      check("badstop_ready", {31'd0, key_ready}, 0);
      send(8'h32);
      read_expect("B_kbd", 0, 8'hC2);

      send(8'h1C); send(8'h32);
      read_expect("ovr_cr", 1, 8'hC0);
      read_expect("ovr_kbd", 0, 8'hC2);
      read_expect("ovr_cr2", 1, 8'h00);

      send(8'h78);
      check("f11_ready", {31'd0, key_ready}, 0);
      check("f11_count", obs_clr, 1);
      send(8'h07);
      check("f12_count", obs_rst, 1);
      send(8'hF0); send(8'h78);
      check("f11_break", obs_clr, 1);

      send_frame(8'h00, 0, 0, 4, -1);
      repeat (TB_TIMEOUT + 40) @(negedge sys_clock);
      send(8'h5A);
      read_expect("timeout_cr", 0, 8'h8D);

      send(8'h14); send(8'h1C);
      read_expect("ctrl_A", 0, 8'h81);
      send(8'hF0); send(8'h14);
      send(8'hE0); send(8'h5A);
      read_expect("kp_enter", 0, 8'h8D);
      send(8'hE0); send(8'h75);
      check("ext_ignored", {31'd0, key_ready}, 0);
      send(8'h12); send(8'h4A); send(8'hF0); send(8'h12);
      read_expect("question", 0, 8'hBF);

      send(8'h1C);
      send_frame(8'h32, 0, 0, 11, 4);
      check("simul_dout", {24'd0, dout}, 8'hC1);
      read_expect("simul_cr", 1, 8'h80);
      read_expect("simul_kbd", 0, 8'hC2);

      send(8'h1C);
      do_read(0, 0);
      check("noclken", {31'd0, key_ready}, 1);
      read_expect("noclken_kbd", 0, 8'hC1);

      send(8'h12);
      send_frame(8'h1C, 0, 0, 5, -1);
      reset_dut();
      send(8'h16);
      read_expect("post_reset", 0, 8'hB1);

      for (int n = 0; n < 80; n++) begin
         k = $urandom_range(0, 11);
         key = pool[$urandom_range(0, pool.size() - 1)];
         if (k <= 4) begin
            send(key);
            if ($urandom_range(0, 1) == 1) begin send(8'hF0); send(key); end
         end
         else if (k == 5) send($urandom_range(0, 1) ? 8'h12 : 8'h59);
         else if (k == 6) begin send(8'hF0); send($urandom_range(0, 1) ? 8'h12 : 8'h59); end
         else if (k == 7) begin if ($urandom_range(0, 1) == 1) send(8'hF0); send(8'h14); end
         else if (k == 8) begin
            send(8'hE0);
            if ($urandom_range(0, 2) == 0) send(8'hF0);
            case ($urandom_range(0, 2))
               0: send(8'h5A);
               1: send(8'h75);
               default: send(8'h6B);
            endcase
         end
         else if (k == 9) begin
            case ($urandom_range(0, 3))
               0: send(8'h05);
               1: send(8'h11);
               2: send(8'h58);
               default: send(8'h0D);
            endcase
         end
         else if (k == 10) send_frame(key, 1, 0, 11, -1);
         else send(($urandom_range(0, 3) == 0) ? 8'h78 : key);
         if ($urandom_range(0, 2) == 0)
            do_read($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      end
      do_read(0, 1);
      repeat (4) @(negedge sys_clock);
      check("clr_total", obs_clr, m_clr);
      check("rst_total", obs_rst, m_rst);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
